mul_div_ctrl: RTL
=================

Name: mul_div_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage. It serves MULT, MULTU, DIV and DIVU.
- Contains a 32-iteration shift-add multiplier and a shift-subtract divider, plus the FSM that sequences them.
- Raises a stall request to the pipeline controller while busy. Presents the final HI/LO pair for the EX-to-MEM bus.
- Replaces the single-cycle multiplier path for all four ops.

Parameters:
STALL_W, 6, width of the pipeline stall bus; bit 2 is the EX stage.
ITER, 32, number of iteration cycles per operation.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
stall  input  STALL_W  pipeline stall vector; stall[2]==1 means EX is held
start_i  input  1  EX holds a mult/multu/div/divu instruction
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src1_i  input  32  rs operand (multiplicand / dividend)
src2_i  input  32  rt operand (multiplier / divisor)
annul_i  input  1  cancel the in-flight operation (flush)
stallreq_o  output  1  request EX stall
ready_o  output  1  hi_o/lo_o hold the valid result
hi_o  output  32  product[63:32] or remainder
lo_o  output  32  product[31:0] or quotient

Behaviour:
- Reset: all outputs 0, FSM = IDLE, iteration counter = 0. Reset mid-operation aborts with no result.
- FSM states: IDLE, BUSY, DIVZ, DONE.
- IDLE:
  - When start_i=1 and annul_i=0: latch op_i and |src1|,|src2| for signed ops (raw values for unsigned ops). Also latch sign flags s1=src1[31], s2=src2[31] (signed ops only).
  - Divide op with src2_i==0: go to DIVZ. Otherwise go to BUSY with counter=0.
  - stallreq_o = start_i & ~annul_i, combinational, so EX stalls in the start cycle itself.
- BUSY:
  - One iteration per cycle.
  - Multiply: 64-bit accumulator adds shifted multiplicand when the current multiplier bit is 1.
  - Divide: 64-bit restoring step {rem,quo} shift-left-1, trial subtract divisor from rem[63:32], set quotient bit when non-negative.
  - stallreq_o=1.
  - After counter reaches ITER-1, go to DONE.
- Sign fix-up, registered on the BUSY→DONE transition:
  - MULT: product negated if s1^s2.
  - DIV: quotient negated if s1^s2; remainder negated if s1.
- DIVZ:
  - One cycle, stallreq_o=1.
  - Then DONE with hi_o=src1 as latched (original, un-negated) and lo_o=32'hFFFFFFFF.
- DONE:
  - ready_o=1, stallreq_o=0, hi_o/lo_o stable.
  - Stay in DONE while stall[2]==1, because downstream is held and EX has not advanced.
  - Return to IDLE on the first cycle with stall[2]==0. No new start is accepted in the DONE state itself.
- Latency: start cycle = T0. ready_o first high at T0+ITER+1 (T0+33) for mul/div, and at T0+2 for divide-by-zero.
- annul_i: in any state, go to IDLE next cycle with ready_o=0 and stallreq_o=0; hi_o/lo_o are not updated. annul_i has priority over start_i in the same cycle.
- start_i falling while BUSY (no annul): the operation completes; the result is still published.
- Width rules:
  - All internal arithmetic is 64-bit.
  - |x| of 0x80000000 = 0x80000000, treated as unsigned.
  - Overflow of DIV 0x80000000 / -1 gives lo=0x80000000, hi=0.
- ready_o is low in every state except DONE.

Test Plan:
1. MULT src1=0xFFFFFFFD (-3), src2=5, start held, stall[2]=0 → stallreq_o high T0..T0+32; at T0+33 ready_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1; IDLE at T0+34.
2. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001 at T0+33.
3. DIV -7/2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 100/7 → lo_o=14, hi_o=2. DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
4. DIVU 0x1234/0 → ready_o at T0+2, hi_o=0x1234, lo_o=0xFFFFFFFF, stallreq_o high only T0..T0+1.
5. MULT started, annul_i pulsed at T0+10 → IDLE at T0+11, stallreq_o=0, ready_o never asserts, hi_o/lo_o keep previous values. Separately, rst at T0+10 → all outputs 0 at T0+11.
6. DIVU completes with stall[2]=1 held 4 extra cycles → ready_o stays 1 and results stable for 5 cycles, no restart; IDLE the cycle after stall[2] drops. A back-to-back MULTU issued then starts correctly.

Source files
------------

// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl: multi-cycle multiply/divide sequencer for the EX stage.
// It serves MULT, MULTU, DIV and DIVU with a shift-add multiplier and a
// restoring shift-subtract divider. The block holds EX through stallreq_o
// while it is busy. It then presents the HI/LO pair until EX advances.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   stall        pipeline stall vector; bit 2 holds EX
//   start_i      EX holds a mult/multu/div/divu instruction
//   op_i         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1_i       rs operand (multiplicand / dividend)
//   src2_i       rt operand (multiplier / divisor)
//   annul_i      flush: abandon the in-flight operation
//   stallreq_o   request an EX stall
//   ready_o      hi_o/lo_o hold a valid result
//   hi_o, lo_o   product[63:32]/[31:0], or remainder/quotient
module mul_div_ctrl #(
  parameter int STALL_W = 6,
  parameter int ITER    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [31:0]        src1_i,
  input  logic [31:0]        src2_i,
  input  logic               annul_i,
  output logic               stallreq_o,
  output logic               ready_o,
  output logic [31:0]        hi_o,
  output logic [31:0]        lo_o
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DIVZ, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   acc;     // product accumulator, or {rem, quo} while dividing
  logic [63:0]   mcand;   // multiplicand, shifted left once per iteration
  logic [31:0]   mplier;  // multiplier (shifted right), or the divisor (fixed)
  logic          is_div;
  logic          s1, s2;  // operand signs; always 0 for unsigned ops

  // Operand magnitudes for the start cycle. 0x80000000 maps to itself,
  // and that value is correct when it is read as unsigned.
  logic        sgn_op;
  logic [31:0] mag1, mag2;
  assign sgn_op = ~op_i[0];
  assign mag1   = (sgn_op & src1_i[31]) ? -src1_i : src1_i;
  assign mag2   = (sgn_op & src2_i[31]) ? -src2_i : src2_i;

  // One iteration of either engine.
  logic [63:0] mul_nxt, div_nxt, nxt;
  logic [33:0] diff;
  assign mul_nxt = acc + (mplier[0] ? mcand : 64'd0);
  // The shifted remainder can reach 33 bits, so the trial uses acc[63:31].
  assign diff    = {1'b0, acc[63:31]} - {2'b00, mplier};
  assign div_nxt = diff[33] ? {acc[62:0], 1'b0}
                            : {diff[31:0], acc[30:0], 1'b1};
  assign nxt     = is_div ? div_nxt : mul_nxt;

  // Sign fix-up applied to the value produced by the last iteration.
  logic [31:0] quo_f, rem_f;
  logic [63:0] fixed;
  assign quo_f = (s1 ^ s2) ? -nxt[31:0]  : nxt[31:0];
  assign rem_f = s1        ? -nxt[63:32] : nxt[63:32];
  assign fixed = is_div ? {rem_f, quo_f} : ((s1 ^ s2) ? -nxt : nxt);

  // The stall request is combinational in IDLE, so EX also stalls in the
  // start cycle.
  always_comb begin
    stallreq_o = 1'b0;
    case (state)
      IDLE:       stallreq_o = start_i & ~annul_i;
      BUSY, DIVZ: stallreq_o = 1'b1;
      default:    stallreq_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      is_div  <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
      ready_o <= 1'b0;
    end else if (annul_i) begin
      // A flush leaves the published HI/LO untouched.
      state   <= IDLE;
      cnt     <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            is_div <= op_i[1];
            s1     <= sgn_op & src1_i[31];
            s2     <= sgn_op & src2_i[31];
            cnt    <= '0;
            if (op_i[1] && (src2_i == 32'd0)) begin
              // Keep the raw dividend; it becomes HI unchanged.
              state <= DIVZ;
              acc   <= {32'd0, src1_i};
            end else begin
              state  <= BUSY;
              mcand  <= {32'd0, mag1};
              mplier <= mag2;
              acc    <= op_i[1] ? {32'd0, mag1} : 64'd0;
            end
          end
        end
        BUSY: begin
          acc   <= nxt;
          mcand <= {mcand[62:0], 1'b0};
          if (!is_div) mplier <= {1'b0, mplier[31:1]};
          if (cnt == LAST) begin
            state   <= DONE;
            ready_o <= 1'b1;
            hi_o    <= fixed[63:32];
            lo_o    <= fixed[31:0];
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIVZ: begin
          state   <= DONE;
          ready_o <= 1'b1;
          hi_o    <= acc[31:0];
          lo_o    <= 32'hFFFF_FFFF;
        end
        DONE: begin
          // Hold the result while downstream keeps EX frozen.
          if (!stall[2]) begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the EX bit of the stall vector matters here.
  logic unused_stall;
  if (STALL_W > 3) begin : g_hi
    assign unused_stall = ^{stall[STALL_W-1:3], stall[1:0]};
  end else begin : g_lo
    assign unused_stall = ^stall[1:0];
  end

endmodule
